// File: rtl/game_pkg.sv
// game_pkg: shared types, constants and helpers for the game display blocks.
//   timer_state_t    : countdown timer state (IDLE, RUN, EXPIRED)
//   BCD_MAX_ONES     : largest BCD ones digit (9)
//   BCD_MAX_TENS_SEC : largest tens-of-seconds digit (5)
//   seg7_decode      : BCD digit to active-low segments {g,f,e,d,c,b,a}
package game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timer_state_t;

  localparam logic [3:0] BCD_MAX_ONES     = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS_SEC = 4'd5;

  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD digit that counts down and wraps 0 -> MAX.
//   clk    in  : system clock
//   rst_n  in  : asynchronous active-low reset (digit clears to 0)
//   dec    in  : decrement this digit on the next edge
//   ld     in  : load d (clamped to MAX); wins over dec
//   d      in  : value to load
//   q      out : current digit
//   borrow out : combinational, high when dec hits 0 and the next digit
//                up must decrement on the same edge
module bcd_down_digit
  import game_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX_ONES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec,
  input  logic       ld,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       borrow
);

  assign borrow = dec && (q == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (ld) begin
      q <= (d > MAX) ? MAX : d;
    end else if (dec) begin
      q <= borrow ? MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS down counter with 4-digit seven-segment scan.
//   FRAMES_PER_SEC : frame ticks per decremented second (2..1023)
//   clk     in  : system clock
//   reset_n in  : asynchronous active-low reset (release synchronised)
//   load    in  : pulse, captures preset (clamped per digit)
//   preset  in  : BCD {min tens, min ones, sec tens, sec ones}
//   start   in  : level, 1 = run, 0 = pause
//   frame   in  : one tick per video frame
//   digsel  in  : advances the digit scan
//   f_clk   in  : slow flash clock, used only with COUNTDOWN_FLASH_EN
//   an      out : digit anodes, active-low
//   seg     out : segments, active-low, seg[0] = a
//   running out : high in RUN
//   expired out : high in EXPIRED
// Build option: define COUNTDOWN_FLASH_EN to blink the anodes with f_clk
// when expired or when the running value is 00:10 or less.
module countdown_timer
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] preset,
  input  logic        start,
  input  logic        frame,
  input  logic        digsel,
  input  logic        f_clk,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        running,
  output logic        expired
);

  logic         rst_meta_n;
  logic         rst_n_s;
  timer_state_t state, state_nx;
  logic [9:0]   frame_cnt;
  logic [3:0]   sec_ones, sec_tens, min_ones, min_tens;
  logic         b_so, b_st, b_mo, unused_b_mt;
  logic         counting, sec_end, tick, value_zero, last_sec;
  logic [3:0]   ring;
  logic [3:0]   digit;

  // Reset asserts immediately, deasserts two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_n <= 1'b0;
      rst_n_s    <= 1'b0;
    end else begin
      rst_meta_n <= 1'b1;
      rst_n_s    <= rst_meta_n;
    end
  end

  // Only a frame seen while running and still enabled advances time.
  assign counting   = (state == RUN) && start && frame && !load;
  assign sec_end    = (frame_cnt == 10'(FRAMES_PER_SEC - 1));
  assign tick       = counting && sec_end;
  assign value_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
  assign last_sec   = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      frame_cnt <= 10'd0;
    end else if (load) begin
      frame_cnt <= 10'd0;
    end else if (counting) begin
      frame_cnt <= sec_end ? 10'd0 : frame_cnt + 10'd1;
    end
  end

  bcd_down_digit #(.MAX(BCD_MAX_ONES)) u_sec_ones (
    .clk(clk), .rst_n(rst_n_s), .dec(tick), .ld(load),
    .d(preset[3:0]), .q(sec_ones), .borrow(b_so)
  );

  bcd_down_digit #(.MAX(BCD_MAX_TENS_SEC)) u_sec_tens (
    .clk(clk), .rst_n(rst_n_s), .dec(b_so), .ld(load),
    .d(preset[7:4]), .q(sec_tens), .borrow(b_st)
  );

  bcd_down_digit #(.MAX(BCD_MAX_ONES)) u_min_ones (
    .clk(clk), .rst_n(rst_n_s), .dec(b_st), .ld(load),
    .d(preset[11:8]), .q(min_ones), .borrow(b_mo)
  );

  // Never borrows in practice: counting stops at 00:00.
  bcd_down_digit #(.MAX(BCD_MAX_ONES)) u_min_tens (
    .clk(clk), .rst_n(rst_n_s), .dec(b_mo), .ld(load),
    .d(preset[15:12]), .q(min_tens), .borrow(unused_b_mt)
  );

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (load) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = value_zero ? EXPIRED : RUN;
        RUN: begin
          if (!start) begin
            state_nx = IDLE;
          end else if (tick && last_sec) begin
            state_nx = EXPIRED;
          end
        end
        EXPIRED: state_nx = EXPIRED;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign expired = (state == EXPIRED);

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      ring <= 4'b0001;
    end else if (digsel) begin
      ring <= {ring[2:0], ring[3]};
    end
  end

  always_comb begin
    case (ring)
      4'b0001: digit = sec_ones;
      4'b0010: digit = sec_tens;
      4'b0100: digit = min_ones;
      default: digit = min_tens;
    endcase
  end

  assign seg = seg7_decode(digit);

`ifdef COUNTDOWN_FLASH_EN
  logic low_time;
  logic blank;

  // 00:00 .. 00:10
  assign low_time = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                    ((sec_tens == 4'd0) || ((sec_tens == 4'd1) && (sec_ones == 4'd0)));
  assign blank    = !f_clk && ((state == EXPIRED) || ((state == RUN) && low_time));
  assign an       = blank ? 4'b1111 : ~ring;
`else
  logic unused_f_clk;
  assign unused_f_clk = f_clk;
  assign an           = ~ring;
`endif

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Counts a loaded MM:SS value down to 00:00 and scans it onto the 4-digit seven-segment display. It is the down-counting counterpart of the elapsed-time display and serves as the game's round/obstacle time limit. It takes the same frame-tick and digit-select strobes and raises `expired` for the game FSM when time runs out.

## Interface
- `FRAMES_PER_SEC`, 60: `frame` pulses per decremented second (2..1023).
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `load` in 1: one-cycle pulse that captures `preset`.
- `preset` in 16: BCD {min tens, min ones, sec tens, sec ones}.
- `start` in 1: level input; high means run, low means pause.
- `frame` in 1: one-cycle tick per video frame.
- `digsel` in 1: one-cycle tick that advances the digit scan.
- `f_clk` in 1: slow flash clock (about 2 Hz square wave).
- `an` out 4: digit anodes, active-low.
- `seg` out 7: segments, active-low, `seg[0]` = a … `seg[6]` = g.
- `running` out 1: high in RUN.
- `expired` out 1: high in EXPIRED.

## Operation
- States:
  - IDLE: holds the loaded value.
  - RUN: counts down.
  - EXPIRED: sits at 00:00.
- Transitions:
  - IDLE→RUN when `start`=1 and the value is nonzero.
  - IDLE→EXPIRED when `start`=1 and the value is 00:00.
  - RUN→IDLE when `start`=0 (pause). The frame sub-counter is kept, not cleared.
  - RUN→EXPIRED on the edge that makes the value 00:00.
  - Any state→IDLE on `load`.
- Priority: `load` > `start` > `frame`.
- Load behaviour:
  - On `load`, the digits take `preset` and the frame sub-counter clears.
  - Digits over range clamp: ones digits to 9, tens of seconds to 5, tens of minutes to 9. Example: preset 16'h7A6F loads as 79:59.
- Frame counting (RUN only):
  - Each `frame` increments the 10-bit sub-counter.
  - When the sub-counter would reach `FRAMES_PER_SEC`, it wraps to 0 and a one-second borrow is generated on that same edge.
- Borrow chain (combinational, all digits update on one edge):
  - sec ones 0→9 borrows from sec tens.
  - sec tens 0→5 borrows from min ones.
  - min ones 0→9 borrows from min tens.
  - min tens stays ≥0; 00:00 never underflows.
- Display:
  - A 4-bit one-hot ring counter resets to 4'b0001 (digit 0 = sec ones) and rotates left on `digsel`.
  - `an` = ~ring, gated by flash (see Configuration).
  - `seg` is the decimal decode of the selected digit. Digits are always 0–9.

## Timing
- Reset values:
  - state IDLE, digits 00:00, sub-counter 0, ring 4'b0001.
  - `an`=4'b1110, `seg`=7'b1000000 ("0"), `running`=0, `expired`=0.
- `load`: value visible and held on the cycle after the pulse. A `frame` in the same cycle is ignored.
- `running` and `expired` are registered: they change one cycle after the causing input.
- The last second: on the `frame` edge that produces 00:00, digits show 00:00, and `expired` rises on that same edge as the state update.
- `start` deasserted in the same cycle as a borrowing `frame`: pause wins and that frame is not counted.
- `reset_n` low mid-count: everything returns to reset values immediately, independent of `clk`. Reset release is synchronised internally with a 2-flop deassert.

## Configuration
- `COUNTDOWN_FLASH_EN` defined:
  - In EXPIRED, all anodes are blanked (`an`=4'b1111) while `f_clk`=0 and shown while `f_clk`=1.
  - Also in RUN when the value is ≤ 00:10.
- Undefined: `f_clk` is ignored and `an` is always ~ring.

## Structure
- Shared package `game_pkg` holds:
  - the state typedef `timer_state_t` {IDLE, RUN, EXPIRED};
  - constants `BCD_MAX_ONES`=9, `BCD_MAX_TENS_SEC`=5;
  - the 7-segment decode function.
- One sub-module, `bcd_down_digit`: a 4-bit down digit with parameter MAX, inputs `dec`/`ld`/`d`, outputs `q`/`borrow`. It is instantiated four times.

## Test plan
- Reset, then load 16'h0003 with `start`=1 and 60 frames per second → 00:02 after 60 frames. `expired`=1 one cycle after frame 180. The value stays 00:00.
- Load 16'h1000 and run 60 frames → 09:59: the borrow ripples through all digits on one edge.
- Run 30 frames, drop `start` for 100 frames, raise `start`, run 30 more frames → exactly one second decremented.
- Load 16'h7A6F → 79:59 after clamping. Pulse `load` together with `frame` → no decrement.
- `digsel` ×4 → `an` sequence 1110, 1101, 1011, 0111, then 1110. In EXPIRED with `COUNTDOWN_FLASH_EN` defined, `an`=1111 whenever `f_clk`=0.
- Assert `reset_n`=0 mid-count at 05:37 → immediate 00:00 and IDLE. `start` with 00:00 loaded → EXPIRED in 1 cycle.
